snake_game_ctrl: RTL

//  Game sequencer for the snake datapath; sits between keyboard, HVsync and snake_logic.
//  - Runs the IDLE/PLAY/OVER game FSM.
//  - Derives the snake move tick from VGA frame starts.
//  - Latches the legal steering direction.
//  - Keeps score and speed level; snake_logic advances the body only on move_tick.

---
 rtl/snake_game_if.sv | 26 ++
 rtl/snake_game_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/snake_game_if.sv
// Signal bundle between the snake game controller and its environment
// (keyboard, HVsync and snake_logic).
interface snake_game_if #(
  parameter int SCORE_W = 8
);
  logic               reset_game;
  logic               v_sync;
  logic [2:0]         direction;
  logic               collision;
  logic               food_eaten;
  logic               move_tick;
  logic [2:0]         cur_dir;
  logic [1:0]         game_state;
  logic [SCORE_W-1:0] score;
  logic [5:0]         speed_lvl;

  modport master (
    output reset_game, v_sync, direction, collision, food_eaten,
    input  move_tick, cur_dir, game_state, score, speed_lvl
  );

  modport slave (
    input  reset_game, v_sync, direction, collision, food_eaten,
    output move_tick, cur_dir, game_state, score, speed_lvl
  );
endinterface

// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: IDLE/PLAY/OVER FSM, frame-derived move tick,
// steering latch with reversal protection, score and speed level.
module snake_game_ctrl #(
  parameter int START_PERIOD  = 30,
  parameter int MIN_PERIOD    = 4,
  parameter int SPEEDUP_EVERY = 4,
  parameter int SCORE_W       = 8
) (
  input  logic           clk_25,
  input  logic           rst,
  snake_game_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_t;

  localparam logic [5:0] START_P   = 6'(START_PERIOD);
  localparam logic [5:0] MIN_P     = 6'(MIN_PERIOD);
  localparam logic [3:0] SPEEDUP_N = 4'(SPEEDUP_EVERY);

  state_t             state_q, state_d;
  logic               vs_q, vs_d;
  logic               fs_q, fs_d;
  logic               tick_q, tick_d;
  logic [2:0]         cur_q, cur_d;
  logic [2:0]         pend_q, pend_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [5:0]         lvl_q, lvl_d;
  logic [5:0]         period_q, period_d;
  logic [5:0]         fcnt_q, fcnt_d;
  logic [3:0]         food_q, food_d;
  logic               dir_valid;

  function automatic logic [2:0] opposite(input logic [2:0] d);
    case (d)
      3'd1:    opposite = 3'd2;
      3'd2:    opposite = 3'd1;
      3'd3:    opposite = 3'd4;
      3'd4:    opposite = 3'd3;
      default: opposite = 3'd0;
    endcase
  endfunction

  assign dir_valid = (bus.direction != 3'd0) && (bus.direction <= 3'd4);

  always_comb begin
    state_d  = state_q;
    vs_d     = bus.v_sync;
    fs_d     = vs_q & ~bus.v_sync;
    tick_d   = 1'b0;
    cur_d    = cur_q;
    pend_d   = pend_q;
    score_d  = score_q;
    lvl_d    = lvl_q;
    period_d = period_q;
    fcnt_d   = fcnt_q;
    food_d   = food_q;

    case (state_q)
      IDLE: begin
        if (!bus.reset_game && dir_valid) begin
          state_d  = PLAY;
          cur_d    = bus.direction;
          pend_d   = bus.direction;
          score_d  = '0;
          lvl_d    = '0;
          food_d   = '0;
          fcnt_d   = '0;
          period_d = START_P;
        end
      end
      PLAY: begin
        // reset_game outranks collision, which in turn swallows food and ticks
        if (bus.reset_game) begin
          state_d = IDLE;
        end else if (bus.collision) begin
          state_d = OVER;
        end else begin
          if (dir_valid && (bus.direction != opposite(cur_q)))
            pend_d = bus.direction;

          // >= lets a freshly shortened period fire on the very next frame
          if (fs_q) begin
            if (fcnt_q >= period_q - 6'd1) begin
              fcnt_d = '0;
              tick_d = 1'b1;
              cur_d  = pend_q;
            end else begin
              fcnt_d = fcnt_q + 6'd1;
            end
          end

          if (bus.food_eaten) begin
            if (score_q != {SCORE_W{1'b1}})
              score_d = score_q + SCORE_W'(1);
            if (food_q + 4'd1 >= SPEEDUP_N) begin
              food_d   = '0;
              lvl_d    = (lvl_q != 6'd63) ? lvl_q + 6'd1 : lvl_q;
              period_d = (period_q > MIN_P) ? period_q - 6'd1 : MIN_P;
            end else begin
              food_d = food_q + 4'd1;
            end
          end
        end
      end
      OVER: begin
        if (bus.reset_game)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_25 or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      vs_q     <= 1'b1;
      fs_q     <= 1'b0;
      tick_q   <= 1'b0;
      cur_q    <= 3'd4;
      pend_q   <= 3'd4;
      score_q  <= '0;
      lvl_q    <= '0;
      period_q <= START_P;
      fcnt_q   <= '0;
      food_q   <= '0;
    end else begin
      state_q  <= state_d;
      vs_q     <= vs_d;
      fs_q     <= fs_d;
      tick_q   <= tick_d;
      cur_q    <= cur_d;
      pend_q   <= pend_d;
      score_q  <= score_d;
      lvl_q    <= lvl_d;
      period_q <= period_d;
      fcnt_q   <= fcnt_d;
      food_q   <= food_d;
    end
  end

  assign bus.move_tick  = tick_q;
  assign bus.cur_dir    = cur_q;
  assign bus.game_state = state_q;
  assign bus.score      = score_q;
  assign bus.speed_lvl  = lvl_q;

endmodule
